// File: rtl/clock_pkg.sv
// Shared types and helpers for the digital clock core and its display scanner.
package clock_pkg;

  // Time-set state machine states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  // All segments off.
  localparam logic [6:0] BLANK = 7'h00;

  // Digit code the scanner renders as BLANK (any code >= 10 does).
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // BCD digit to active-high segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return BLANK;
    endcase
  endfunction

endpackage

// File: rtl/digital_clock_core_seg_scan.sv
// Multiplexed 7-segment scanner: dwell counter, digit index, one-hot anode
// and segment outputs, all registered together so seg and an never disagree.
module seg_scan
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DWELL      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIGITS-1:0][3:0] digits,
  input  logic                       pm_in,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       pm
);

  localparam int unsigned DW = cnt_width(DWELL);
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [DW-1:0] dwell_cnt;
  logic [IW-1:0] idx;

  // Advance the digit index once every DWELL cycles, wrapping at the last digit.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (!rst) begin
      dwell_cnt <= '0;
      idx       <= '0;
    end else if (dwell_cnt == DWELL_LAST) begin
      dwell_cnt <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Register segments, anode and pm from the current index in one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= BLANK;
      an  <= '0;
      pm  <= 1'b0;
    end else begin
      seg <= bcd_to_seg(digits[idx]);
      an  <= NUM_DIGITS'(1) << idx;
      pm  <= pm_in;
    end
  end

endmodule

// File: rtl/digital_clock_core.sv
// HH:MM(:SS) clock: second tick, BCD time chain, time-set FSM with blinking
// edit field, 12/24-hour display mapping, feeding the segment scanner.
module digital_clock_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_btn,
  input  logic                  inc_btn,
  input  logic                  fmt_12h,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  pm,
  output logic                  sec_tick
);

  localparam int unsigned DWELL      = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TW = cnt_width(CLK_HZ);
  localparam int unsigned BW = cnt_width(BLINK_HALF);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    s_hi, s_lo, m_hi, m_lo, h_hi, h_lo;

  logic          tick_evt, inc_evt;
  logic [3:0]    s_hi_inc, s_lo_inc, m_hi_inc, m_lo_inc, h_hi_inc, h_lo_inc;
  logic          s_wrap, m_wrap;
  logic [3:0]    dh_hi, dh_lo;
  logic          is_pm;
  logic          hour_blank, min_blank;
  logic [3:0]    c_h_hi, c_h_lo, c_m_hi, c_m_lo;
  logic [NUM_DIGITS-1:0][3:0] digits;

  // A second elapses only while running; mode beats inc in the same cycle.
  assign tick_evt = (state == RUN) && (tick_cnt == TICK_LAST);
  assign inc_evt  = inc_btn && !mode_btn && (state != RUN);
  assign sec_tick = tick_evt;

  // Next-state logic: mode_btn steps RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    state_next = state;
    if (mode_btn) begin
      case (state)
        RUN:      state_next = SET_HOUR;
        SET_HOUR: state_next = SET_MIN;
        default:  state_next = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Second counter: counts in RUN, held at zero in (and on leaving) the set states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state != RUN || state_next != RUN) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // BCD successors of seconds, minutes and hours, with wrap flags for the carry chain.
  always_comb begin
    s_lo_inc = s_lo + 4'd1;
    s_hi_inc = s_hi;
    s_wrap   = 1'b0;
    if (s_lo == 4'd9) begin
      s_lo_inc = 4'd0;
      if (s_hi == 4'd5) begin
        s_hi_inc = 4'd0;
        s_wrap   = 1'b1;
      end else begin
        s_hi_inc = s_hi + 4'd1;
      end
    end

    m_lo_inc = m_lo + 4'd1;
    m_hi_inc = m_hi;
    m_wrap   = 1'b0;
    if (m_lo == 4'd9) begin
      m_lo_inc = 4'd0;
      if (m_hi == 4'd5) begin
        m_hi_inc = 4'd0;
        m_wrap   = 1'b1;
      end else begin
        m_hi_inc = m_hi + 4'd1;
      end
    end

    h_hi_inc = h_hi;
    h_lo_inc = h_lo + 4'd1;
    if (h_hi == 4'd2 && h_lo == 4'd3) begin
      h_hi_inc = 4'd0;
      h_lo_inc = 4'd0;
    end else if (h_lo == 4'd9) begin
      h_hi_inc = h_hi + 4'd1;
      h_lo_inc = 4'd0;
    end
  end

  // Time registers: clear seconds on leaving SET_MIN, advance on tick, or apply a set increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_hi <= 4'd0; s_lo <= 4'd0;
      m_hi <= 4'd0; m_lo <= 4'd0;
      h_hi <= 4'd0; h_lo <= 4'd0;
    end else if (mode_btn && state == SET_MIN) begin
      s_hi <= 4'd0;
      s_lo <= 4'd0;
    end else if (tick_evt) begin
      s_hi <= s_hi_inc;
      s_lo <= s_lo_inc;
      if (s_wrap) begin
        m_hi <= m_hi_inc;
        m_lo <= m_lo_inc;
        if (m_wrap) begin
          h_hi <= h_hi_inc;
          h_lo <= h_lo_inc;
        end
      end
    end else if (inc_evt && state == SET_HOUR) begin
      h_hi <= h_hi_inc;
      h_lo <= h_lo_inc;
    end else if (inc_evt && state == SET_MIN) begin
      m_hi <= m_hi_inc;
      m_lo <= m_lo_inc;
    end
  end

  // Free-running blink phase; an accepted increment restarts it in the visible half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (inc_evt) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Map stored 24-hour time onto the displayed hour digits.
  always_comb begin
    is_pm = (h_hi == 4'd2) || (h_hi == 4'd1 && h_lo >= 4'd2);
    dh_hi = h_hi;
    dh_lo = h_lo;
    if (fmt_12h) begin
      if (h_hi == 4'd0 && h_lo == 4'd0) begin
        dh_hi = 4'd1;
        dh_lo = 4'd2;
      end else if (h_hi == 4'd1 && h_lo >= 4'd3) begin
        dh_hi = 4'd0;
        dh_lo = h_lo - 4'd2;
      end else if (h_hi == 4'd2 && h_lo <= 4'd1) begin
        dh_hi = 4'd0;
        dh_lo = h_lo + 4'd8;
      end else if (h_hi == 4'd2) begin
        dh_hi = 4'd1;
        dh_lo = h_lo - 4'd2;
      end
    end
  end

  assign hour_blank = blink_phase && (state == SET_HOUR);
  assign min_blank  = blink_phase && (state == SET_MIN);

  assign c_h_hi = (hour_blank || (fmt_12h && dh_hi == 4'd0)) ? BLANK_CODE : dh_hi;
  assign c_h_lo = hour_blank ? BLANK_CODE : dh_lo;
  assign c_m_hi = min_blank  ? BLANK_CODE : m_hi;
  assign c_m_lo = min_blank  ? BLANK_CODE : m_lo;

  // Digit order from an[0] upward; the 4-digit build keeps seconds but does not show them.
  generate
    if (NUM_DIGITS == 6) begin : g_six
      assign digits = {c_h_hi, c_h_lo, c_m_hi, c_m_lo, s_hi, s_lo};
    end else begin : g_four
      assign digits = {c_h_hi, c_h_lo, c_m_hi, c_m_lo};
    end
  endgenerate

  seg_scan #(
    .NUM_DIGITS(NUM_DIGITS),
    .DWELL     (DWELL)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .digits(digits),
    .pm_in (fmt_12h && is_pm),
    .seg   (seg),
    .an    (an),
    .pm    (pm)
  );

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench for digital_clock_core: a 6-digit and a 4-digit instance
// share all inputs so time, FSM, blink and scan order are checked on pins.
module tb_digital_clock_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       fmt_12h = 1'b0;
  logic [6:0] seg6, seg4;
  logic [5:0] an6;
  logic [3:0] an4;
  logic       pm6, pm4, tick6, tick4;

  int checks = 0;
  int errors = 0;
  logic [6:0] cap6 [6];

  always #5 clk = ~clk;

  // Dwell = 60 / (2*6) = 5 cycles.
  digital_clock_core #(.CLK_HZ(60), .REFRESH_HZ(2), .BLINK_HZ(2), .NUM_DIGITS(6)) dut6 (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .fmt_12h(fmt_12h),
    .seg(seg6), .an(an6), .pm(pm6), .sec_tick(tick6)
  );

  // Refresh 3 keeps the 4-digit dwell at 60 / (3*4) = 5 cycles as well.
  digital_clock_core #(.CLK_HZ(60), .REFRESH_HZ(3), .BLINK_HZ(2), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .fmt_12h(fmt_12h),
    .seg(seg4), .an(an4), .pm(pm4), .sec_tick(tick4)
  );

  // Reference segment patterns (g..a); -1 means blank.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse, applied on the edge after it is raised.
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    mode_btn = m;
    inc_btn  = i;
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  // Edges counted until sec_tick is seen at a falling edge (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (tick6) break;
    end
  endtask

  // Let the pipeline settle, then collect one segment pattern per digit of dut6.
  task automatic capture6();
    logic [5:0] seen;
    seen = '0;
    repeat (7) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (an6 == 6'(1 << i)) begin
          cap6[i] = seg6;
          seen[i] = 1'b1;
        end
      end
      if (seen == 6'h3F) break;
    end
    check("capture_complete", 32'(seen), 32'h3F);
  endtask

  task automatic expect6(input string tag, input int hh, input int hl, input int mh,
                         input int ml, input int sh, input int sl);
    capture6();
    check({tag, "_h_hi"}, 32'(cap6[5]), 32'(seg_of(hh)));
    check({tag, "_h_lo"}, 32'(cap6[4]), 32'(seg_of(hl)));
    check({tag, "_m_hi"}, 32'(cap6[3]), 32'(seg_of(mh)));
    check({tag, "_m_lo"}, 32'(cap6[2]), 32'(seg_of(ml)));
    check({tag, "_s_hi"}, 32'(cap6[1]), 32'(seg_of(sh)));
    check({tag, "_s_lo"}, 32'(cap6[0]), 32'(seg_of(sl)));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic [3:0] prev;
    logic       found;
    logic       any_tick;

    // ---- Reset state ----
    #1 rst = 1'b0;
    #11;
    check("rst_seg", 32'(seg6), 32'h0);
    check("rst_an6", 32'(an6), 32'h0);
    check("rst_an4", 32'(an4), 32'h0);
    check("rst_pm", 32'(pm6), 32'h0);
    check("rst_tick", 32'(tick6), 32'h0);

    // ---- Release: first edge lights digit 0, first tick in cycle 60 ----
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        check("first_edge_an6", 32'(an6), 32'h01);
        check("first_edge_an4", 32'(an4), 32'h1);
        check("first_edge_seg", 32'(seg6), 32'(seg_of(0)));
      end
      if (tick6) break;
    end
    check("first_tick_edges", 32'(n), 32'd59);
    check("first_tick4", 32'(tick4), 32'h1);
    expect6("t1", 0, 0, 0, 0, 0, 1);

    // ---- Asynchronous reset in mid-cycle, past two seconds ----
    repeat (35) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_seg", 32'(seg6), 32'h0);
    check("async_an6", 32'(an6), 32'h0);
    check("async_an4", 32'(an4), 32'h0);
    check("async_pm", 32'(pm6), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("held_an6", 32'(an6), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rerelease_an6", 32'(an6), 32'h01);
    expect6("after_reset", 0, 0, 0, 0, 0, 0);

    // ---- Set FSM ----
    press(1'b1, 1'b0);
    any_tick = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (tick6) any_tick = 1'b1;
    end
    check("no_tick_in_set", 32'(any_tick), 32'h0);
    repeat (25) press(1'b0, 1'b1);   // 00 + 25 -> 01
    press(1'b1, 1'b1);               // mode wins: SET_MIN, hour stays 01
    press(1'b0, 1'b1);               // minute 01
    press(1'b1, 1'b0);               // back to RUN, seconds and tick counter cleared
    wait_tick(n);
    check("tick_after_set", 32'(n), 32'd59);
    press(1'b0, 1'b1);               // ignored in RUN
    expect6("run_inc_ignored", 0, 1, 0, 1, 0, 1);

    // ---- Blink in SET_MIN ----
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);               // minute 02, phase restarts visible
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k <= 15) begin
        case (an4)
          4'b0001: check("vis_m_lo", 32'(seg4), 32'(seg_of(2)));
          4'b0010: check("vis_m_hi", 32'(seg4), 32'(seg_of(0)));
          4'b0100: check("vis_h_lo", 32'(seg4), 32'(seg_of(1)));
          4'b1000: check("vis_h_hi", 32'(seg4), 32'(seg_of(0)));
          default: ;
        endcase
      end else if (k <= 30) begin
        case (an4)
          4'b0001: check("blank_m_lo", 32'(seg4), 32'h0);
          4'b0010: check("blank_m_hi", 32'(seg4), 32'h0);
          4'b0100: check("blank_h_lo_lit", 32'(seg4), 32'(seg_of(1)));
          4'b1000: check("blank_h_hi_lit", 32'(seg4), 32'(seg_of(0)));
          default: ;
        endcase
      end
    end
    press(1'b0, 1'b1);               // mid-blank inc: minute 03, visible again
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      case (an4)
        4'b0001: check("reshow_m_lo", 32'(seg4), 32'(seg_of(3)));
        4'b0010: check("reshow_m_hi", 32'(seg4), 32'(seg_of(0)));
        4'b0100: check("reshow_h_lo", 32'(seg4), 32'(seg_of(1)));
        4'b1000: check("reshow_h_hi", 32'(seg4), 32'(seg_of(0)));
        default: ;
      endcase
    end
    press(1'b1, 1'b0);

    // ---- Rollover from 23:59 ----
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    press(1'b1, 1'b0);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);               // RUN at 23:59:00
    for (int t = 0; t < 59; t++) begin
      wait_tick(n);
      check("tick_spacing", 32'(n), (t == 0) ? 32'd59 : 32'd60);
    end
    expect6("pre_roll", 2, 3, 5, 9, 5, 9);
    wait_tick(n);
    check("roll_tick_seen", 32'(tick6), 32'h1);
    expect6("rolled", 0, 0, 0, 0, 0, 0);

    // ---- 12-hour format ----
    fmt_12h = 1'b1;
    wait_tick(n);
    expect6("h12_midnight", 1, 2, 0, 0, 0, 1);
    check("h12_midnight_pm", 32'(pm6), 32'h0);
    press(1'b1, 1'b0);
    repeat (13) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);               // RUN at 13:00:00
    expect6("h12_13", -1, 1, 0, 0, 0, 0);
    check("h12_13_pm6", 32'(pm6), 32'h1);
    check("h12_13_pm4", 32'(pm4), 32'h1);
    @(negedge clk);
    fmt_12h = 1'b0;
    wait_tick(n);
    expect6("h24_13", 1, 3, 0, 0, 0, 1);
    check("h24_13_pm", 32'(pm6), 32'h0);

    // ---- 4-digit scan order and dwell ----
    prev  = an4;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an4 == 4'b0001 && prev == 4'b1000) begin
        found = 1'b1;
        break;
      end
      prev = an4;
    end
    check("scan_sync", 32'(found), 32'h1);
    for (int s = 1; s < 25; s++) begin
      @(negedge clk);
      check("scan_an", 32'(an4), 32'(4'b0001 << ((s / 5) % 4)));
      case ((s / 5) % 4)
        0:       check("scan_m_lo", 32'(seg4), 32'(seg_of(0)));
        1:       check("scan_m_hi", 32'(seg4), 32'(seg_of(0)));
        2:       check("scan_h_lo", 32'(seg4), 32'(seg_of(3)));
        default: check("scan_h_hi", 32'(seg4), 32'(seg_of(1)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digital_clock_core.md
# digital_clock_core

Parametrised successor to the 6-digit clock top: a single-clock-domain HH:MM(:SS) clock with 12/24-hour display format, a button-driven time-set state machine with blinking edit field, and an integrated multiplexed 7-segment scanner. Timing is derived from clock-enable ticks rather than divided clocks. It sits directly under the board top and drives the segment and anode pins.

## Interface

- CLK_HZ, 100_000_000: input clock frequency; one second = CLK_HZ cycles.
- REFRESH_HZ, 1000: full-frame scan rate; per-digit dwell = floor(CLK_HZ / (REFRESH_HZ*NUM_DIGITS)) cycles, which must be ≥1.
- BLINK_HZ, 2: edit-field blink rate; half period = floor(CLK_HZ / (2*BLINK_HZ)) cycles.
- NUM_DIGITS, 6: 6 = HH:MM:SS, 4 = HH:MM (seconds kept but not shown); other values illegal.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_btn  in  1  single-cycle pulse, already debounced and synchronised; advances set FSM.
- inc_btn  in  1  single-cycle pulse, already debounced and synchronised; increments edited field.
- fmt_12h  in  1  level; 1 = 12-hour display, 0 = 24-hour display.
- seg  out  7  active-high segments, seg[0]=a … seg[6]=g.
- an  out  NUM_DIGITS  one-hot, active-high digit enable; an[0] = rightmost digit.
- pm  out  1  high when displayed time is PM in 12-hour mode; 0 in 24-hour mode.
- sec_tick  out  1  one-cycle pulse per elapsed second while in RUN.

## Operation

- Time is held in BCD: s_hi:s_lo (00–59), m_hi:m_lo (00–59), h_hi:h_lo (00–23). No divide/modulo hardware.
- FSM states are RUN, SET_HOUR, and SET_MIN.
  - RUN → SET_HOUR on mode_btn.
  - SET_HOUR → SET_MIN on mode_btn.
  - SET_MIN → RUN on mode_btn; the seconds field is cleared to 00 and the tick counter to 0 on this transition.
- RUN: the tick counter counts 0..CLK_HZ-1 and wraps.
  - At terminal count, sec_tick=1 and the time increments on that edge.
  - Carry chain: 59s→00s with minute +1; 59m→00m with hour +1; 23:59:59→00:00:00.
- SET_HOUR and SET_MIN: the tick counter is held at 0, time does not advance, and sec_tick=0.
  - inc_btn in SET_HOUR: hour +1, wrapping 23→00.
  - inc_btn in SET_MIN: minute +1, wrapping 59→00, with no carry into the hour.
  - inc_btn in RUN is ignored.
- mode_btn and inc_btn in the same cycle: mode wins and inc is dropped.
- 12-hour mapping:
  - Hour 00 displays 12 (AM); 01–11 display as-is (AM).
  - Hour 12 displays 12 (PM); 13–23 display h−12 (PM).
  - A hour-tens digit of 0 is blanked (seg=0) in 12-hour mode only.
  - Internal storage is always 24-hour; toggling fmt_12h never alters the time.
- Blink: a free-running phase toggles every blink half period.
  - In a set state, the digits of the edited field are blanked while phase=1.
  - inc_btn resets the phase to 0 (visible), so a press is always seen immediately.
- Digit order (an[0] upward):
  - NUM_DIGITS=6: s_lo, s_hi, m_lo, m_hi, h_lo, h_hi.
  - NUM_DIGITS=4: m_lo, m_hi, h_lo, h_hi.

## Timing

- Reset (rst=0, asynchronous): time 00:00:00, state RUN, tick/scan/blink counters 0, blink phase 0, digit index 0, seg=0, an=0, pm=0, sec_tick=0.
- After reset release, first rising edge: an=1 and seg shows digit 0.
- First sec_tick occurs in cycle CLK_HZ after release (counter reaches CLK_HZ-1).
- seg, an, and pm are registered together, with one cycle of latency from digit index/time to pins, so there is no glitch between seg and an.
- Scan: the digit index advances every dwell cycles and wraps NUM_DIGITS-1→0. an shifts one-hot accordingly and is never all-zero after the first post-reset edge.
- A button pulse takes effect on the edge at the end of its cycle; the display reflects it within one dwell plus one cycle.
- Reset mid-second or mid-set aborts immediately to the reset state.

## Structure

- Package clock_pkg:
  - state enum {RUN, SET_HOUR, SET_MIN};
  - function bcd_to_seg (4-bit → 7-bit, codes ≥10 → blank);
  - BLANK constant 7'h00;
  - $clog2-based width helpers.
- Sub-module seg_scan (dwell counter, digit index, one-hot an, registered seg), parametrised by NUM_DIGITS and dwell.
- All other logic (tick, BCD chain, FSM, 12h mapping, blink) stays in digital_clock_core.

## Test plan

All scenarios use CLK_HZ=60, REFRESH_HZ=2, BLINK_HZ=2, which gives dwell 5 cycles and blink half period 15.

- Reset: run 130 cycles, pulse rst low mid-cycle → seg=0, an=0, pm=0 at once; after release, an=000001 on the first edge and the time reads 00:00:00.
- Rollover: set the hour to 23 (23 incs) and the minute to 59 (59 incs), return to RUN, wait 60 ticks → time goes 23:59:59→00:00:00 with one sec_tick per 60 cycles.
- Set FSM: mode, 25 incs → hour 01; mode+inc in the same cycle → state SET_MIN with minute unchanged; inc in RUN → no change.
- 12-hour format: with hour 00, fmt_12h=1 → hour digits "12", pm=0; with hour 13 → digits blank and "1", pm=1; with fmt_12h=0 → "13", pm=0.
- Scan (NUM_DIGITS=4): an cycles 0001→0010→0100→1000→0001, 5 cycles each, and seg matches m_lo, m_hi, h_lo, h_hi.
- Blink: in SET_MIN, minute digits are blank during phase=1 and the hour digits stay lit; an inc mid-blank → minute digits visible on the next scan.
